// File: rtl/mc_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings,
// RV32I major opcodes, fault codes and opcode classification helpers.
package mc_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_SETUP  = 3'd0,
    SEQ_FETCH  = 3'd1,
    SEQ_DECODE = 3'd2,
    SEQ_EXEC   = 3'd3,
    SEQ_MEM    = 3'd4,
    SEQ_WB     = 3'd5,
    SEQ_HALT   = 3'd6
  } seq_state_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'd1;
  localparam logic [1:0] FAULT_MISALIGN = 2'd2;

  // Opcodes the core executes; SYSTEM (ECALL/EBREAK) is deliberately absent.
  function automatic logic opc_legal(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_MISC_MEM: opc_legal = 1'b1;
      default:                                               opc_legal = 1'b0;
    endcase
  endfunction

  // Opcodes that produce a register-file result.
  function automatic logic opc_writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_OP, OPC_OP_IMM: opc_writes_rd = 1'b1;
      default:                      opc_writes_rd = 1'b0;
    endcase
  endfunction

  // Opcodes that need a data-RAM phase.
  function automatic logic opc_is_mem(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_STORE: opc_is_mem = 1'b1;
      default:             opc_is_mem = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_sequencer_seq_wait_ctr.sv
// 4-bit wait down-counter shared by the FETCH and MEM phases. Loaded with
// latency-1 on phase entry; done is high while the count sits at zero.
module seq_wait_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       done
);

  logic [3:0] cnt_d, cnt_q;

  // Load on phase entry, otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;
  assign done  = (cnt_q == 4'd0);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I sequencer: owns PC/IR, steps instructions through
// FETCH/DECODE/EXEC/MEM/WB, drives memory and register-file enables, and
// handles setup loading, halting and fault reporting.
module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int IMEM_LATENCY = 1,
  parameter int RAM_LATENCY  = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             setup,
  input  logic [XLEN-1:0]  i_start_addr,
  input  logic [31:0]      i_imem_rdata,
  input  logic             i_branch_taken,
  input  logic [XLEN-1:0]  i_next_pc,
  output logic [XLEN-1:0]  o_pc,
  output logic [31:0]      o_ir,
  output logic             o_imem_re,
  output logic             o_reg_we,
  output logic             o_ram_re,
  output logic             o_ram_we,
  output logic [2:0]       o_state,
  output logic             o_halted,
  output logic [1:0]       o_fault,
  output logic [CNT_W-1:0] o_retired
);

  localparam logic [3:0]      IMEM_LOAD = 4'(IMEM_LATENCY - 1);
  localparam logic [3:0]      RAM_LOAD  = 4'(RAM_LATENCY - 1);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(3'd4);

  seq_state_e       state_d, state_q;
  logic [XLEN-1:0]  pc_d, pc_q;
  logic [31:0]      ir_d, ir_q;
  logic [1:0]       fault_d, fault_q;
  logic [CNT_W-1:0] retired_d, retired_q;

  logic             ctr_load;
  logic [3:0]       ctr_val;
  logic [3:0]       ctr_count;
  logic             ctr_done;

  logic [6:0]       opc;
  logic             take_target;
  logic [XLEN-1:0]  next_pc;
  logic             misaligned;

  assign opc = ir_q[6:0];

  seq_wait_ctr u_wait_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ctr_load),
    .load_val (ctr_val),
    .count    (ctr_count),
    .done     (ctr_done)
  );

  // Candidate next PC for the instruction in WB; wraps modulo 2^XLEN.
  always_comb begin
    take_target = (opc == OPC_JAL) || (opc == OPC_JALR) ||
                  ((opc == OPC_BRANCH) && i_branch_taken);
    next_pc     = take_target ? i_next_pc : (pc_q + PC_STEP);
    misaligned  = (next_pc[1:0] != 2'b00);
  end

  // Next-state and datapath update for the sequencer FSM.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    fault_d   = fault_q;
    retired_d = retired_q;
    case (state_q)
      SEQ_SETUP: begin
        pc_d      = i_start_addr;
        retired_d = '0;
        fault_d   = FAULT_NONE;
        state_d   = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        if (ctr_done) begin
          ir_d    = i_imem_rdata;
          state_d = SEQ_DECODE;
        end else begin
          state_d = SEQ_FETCH;
        end
      end
      SEQ_DECODE: begin
        if (opc_legal(opc)) begin
          state_d = SEQ_EXEC;
        end else begin
          state_d = SEQ_HALT;
          fault_d = FAULT_ILLEGAL;
        end
      end
      SEQ_EXEC: begin
        state_d = opc_is_mem(opc) ? SEQ_MEM : SEQ_WB;
      end
      SEQ_MEM: begin
        if (ctr_done) state_d = SEQ_WB;
        else          state_d = SEQ_MEM;
      end
      SEQ_WB: begin
        if (misaligned) begin
          state_d = SEQ_HALT;
          fault_d = FAULT_MISALIGN;
        end else begin
          pc_d      = next_pc;
          retired_d = retired_q + CNT_W'(1);
          state_d   = SEQ_FETCH;
        end
      end
      SEQ_HALT: begin
        state_d = SEQ_HALT;
      end
      default: begin
        state_d = SEQ_SETUP;
      end
    endcase
    // Setup aborts whatever is in flight: the aborted instruction commits no
    // PC or counter update, and SETUP itself keeps loading the start address.
    if (setup) begin
      state_d   = SEQ_SETUP;
      fault_d   = FAULT_NONE;
      ir_d      = ir_q;
      pc_d      = (state_q == SEQ_SETUP) ? i_start_addr : pc_q;
      retired_d = (state_q == SEQ_SETUP) ? '0 : retired_q;
    end else begin
      state_d   = state_d;
    end
  end

  // Reload the wait counter whenever FETCH or MEM is entered.
  always_comb begin
    ctr_load = ((state_d == SEQ_FETCH) && (state_q != SEQ_FETCH)) ||
               ((state_d == SEQ_MEM)   && (state_q != SEQ_MEM));
    ctr_val  = (state_d == SEQ_MEM) ? RAM_LOAD : IMEM_LOAD;
  end

  // Sequencer state and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEQ_SETUP;
      pc_q      <= '0;
      ir_q      <= 32'd0;
      fault_q   <= FAULT_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  // Enables decode from state/IR. The register write also drops when the
  // chosen target is misaligned, so a faulting jump never writes its link.
  assign o_imem_re = (state_q == SEQ_FETCH);
  assign o_ram_re  = (state_q == SEQ_MEM) && (opc == OPC_LOAD) && !setup;
  assign o_ram_we  = (state_q == SEQ_MEM) && (opc == OPC_STORE) &&
                     (ctr_count == RAM_LOAD) && !setup;
  assign o_reg_we  = (state_q == SEQ_WB) && opc_writes_rd(opc) &&
                     (ir_q[11:7] != 5'd0) && !misaligned && !setup;

  assign o_pc      = pc_q;
  assign o_ir      = ir_q;
  assign o_state   = state_q;
  assign o_halted  = (state_q == SEQ_HALT);
  assign o_fault   = fault_q;
  assign o_retired = retired_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer with IMEM_LATENCY=1, RAM_LATENCY=3.
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        setup;
  logic [31:0] i_start_addr;
  logic [31:0] i_imem_rdata;
  logic        i_branch_taken;
  logic [31:0] i_next_pc;
  logic [31:0] o_pc;
  logic [31:0] o_ir;
  logic        o_imem_re, o_reg_we, o_ram_re, o_ram_we;
  logic [2:0]  o_state;
  logic        o_halted;
  logic [1:0]  o_fault;
  logic [31:0] o_retired;

  logic [31:0] imem [0:255];
  int passed = 0;
  int total  = 0;

  localparam logic [2:0] S_SETUP = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  always #5 clk = ~clk;

  // Instruction RAM model, word-addressed by the current PC.
  assign i_imem_rdata = imem[o_pc[9:2]];

  mc_sequencer #(
    .XLEN(32), .IMEM_LATENCY(1), .RAM_LATENCY(3), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .setup(setup), .i_start_addr(i_start_addr),
    .i_imem_rdata(i_imem_rdata), .i_branch_taken(i_branch_taken),
    .i_next_pc(i_next_pc), .o_pc(o_pc), .o_ir(o_ir), .o_imem_re(o_imem_re),
    .o_reg_we(o_reg_we), .o_ram_re(o_ram_re), .o_ram_we(o_ram_we),
    .o_state(o_state), .o_halted(o_halted), .o_fault(o_fault),
    .o_retired(o_retired)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two setup cycles then release; returns at the first FETCH sample.
  task automatic do_setup(input logic [31:0] addr);
    setup = 1'b1; i_start_addr = addr;
    step(); step();
    setup = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; setup = 1'b0; i_start_addr = 32'h0;
    i_branch_taken = 1'b0; i_next_pc = 32'h0;
    #12;
    total++; if (o_state !== S_SETUP) $display("FAIL reset_state: got %0d exp %0d", o_state, S_SETUP); else passed++;
    total++; if (o_pc !== 32'h0) $display("FAIL reset_pc: got %h exp %h", o_pc, 32'h0); else passed++;
    total++; if (o_ir !== 32'h0) $display("FAIL reset_ir: got %h exp %h", o_ir, 32'h0); else passed++;
    total++; if ({o_imem_re, o_reg_we, o_ram_re, o_ram_we, o_halted} !== 5'b0)
      $display("FAIL reset_enables: got %b exp 00000", {o_imem_re, o_reg_we, o_ram_re, o_ram_we, o_halted}); else passed++;
    total++; if ({o_fault, o_retired} !== 34'h0) $display("FAIL reset_fault_retired: got %h/%h exp 0/0", o_fault, o_retired); else passed++;
    @(negedge clk); rst_n = 1'b1;
    #1;
  endtask

  task automatic test_fetch_alu();
    int imem_cnt = 0, we_cnt = 0, wb_at = -1;
    setup = 1'b1; i_start_addr = 32'h100;
    step(); step();
    total++; if (o_state !== S_SETUP) $display("FAIL setup_state: got %0d exp %0d", o_state, S_SETUP); else passed++;
    total++; if (o_pc !== 32'h100) $display("FAIL setup_pc: got %h exp %h", o_pc, 32'h100); else passed++;
    setup = 1'b0;
    step();
    total++; if (o_state !== S_FETCH) $display("FAIL first_fetch: got %0d exp %0d", o_state, S_FETCH); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (o_imem_re) imem_cnt++;
      if (o_reg_we) we_cnt++;
      if (o_state == S_WB && wb_at < 0) wb_at = i;
      step();
    end
    total++; if (imem_cnt != 1) $display("FAIL imem_re_cycles: got %0d exp 1", imem_cnt); else passed++;
    total++; if (wb_at != 3) $display("FAIL wb_offset: got %0d exp 3", wb_at); else passed++;
    total++; if (we_cnt != 1) $display("FAIL addi_reg_we: got %0d exp 1", we_cnt); else passed++;
    total++; if (o_ir !== 32'h00500093) $display("FAIL addi_ir: got %h exp %h", o_ir, 32'h00500093); else passed++;
    total++; if (o_state !== S_FETCH || o_pc !== 32'h104) $display("FAIL addi_next: got st %0d pc %h exp st 1 pc 104", o_state, o_pc); else passed++;
  endtask

  task automatic test_store();
    int we_cnt = 0, ram_we_cnt = 0, we_at = -1, re_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (o_reg_we) we_cnt++;
      if (o_ram_re) re_cnt++;
      if (o_ram_we) begin ram_we_cnt++; we_at = i; end
      step();
    end
    total++; if (ram_we_cnt != 1) $display("FAIL sw_ram_we_count: got %0d exp 1", ram_we_cnt); else passed++;
    total++; if (we_at != 3) $display("FAIL sw_ram_we_cycle: got %0d exp 3", we_at); else passed++;
    total++; if (we_cnt != 0 || re_cnt != 0) $display("FAIL sw_other_en: got reg_we %0d ram_re %0d exp 0 0", we_cnt, re_cnt); else passed++;
    total++; if (o_state !== S_FETCH || o_pc !== 32'h108) $display("FAIL sw_7cyc: got st %0d pc %h exp st 1 pc 108", o_state, o_pc); else passed++;
    total++; if (o_retired !== 32'd2) $display("FAIL sw_retired: got %0d exp 2", o_retired); else passed++;
  endtask

  task automatic test_branch();
    int we_cnt = 0;
    i_branch_taken = 1'b1; i_next_pc = 32'h40;
    do_setup(32'h200);
    for (int i = 0; i < 4; i++) begin if (o_reg_we) we_cnt++; step(); end
    total++; if (o_pc !== 32'h40) $display("FAIL beq_taken_pc: got %h exp %h", o_pc, 32'h40); else passed++;
    i_branch_taken = 1'b0; i_next_pc = 32'h80;
    for (int i = 0; i < 4; i++) begin if (o_reg_we) we_cnt++; step(); end
    total++; if (o_pc !== 32'h44) $display("FAIL bne_not_taken_pc: got %h exp %h", o_pc, 32'h44); else passed++;
    total++; if (we_cnt != 0) $display("FAIL branch_reg_we: got %0d exp 0", we_cnt); else passed++;
    total++; if (o_retired !== 32'd2) $display("FAIL branch_retired: got %0d exp 2", o_retired); else passed++;
  endtask

  task automatic test_misaligned_jalr();
    int en_cnt = 0;
    i_next_pc = 32'h102;
    do_setup(32'h300);
    step(); step(); step();
    total++; if (o_state !== S_WB || o_reg_we !== 1'b0) $display("FAIL jalr_wb_reg_we: got st %0d we %b exp st 5 we 0", o_state, o_reg_we); else passed++;
    step();
    total++; if (o_state !== S_HALT || o_halted !== 1'b1) $display("FAIL jalr_halt: got st %0d halted %b exp 6 1", o_state, o_halted); else passed++;
    total++; if (o_fault !== 2'd2) $display("FAIL jalr_fault: got %0d exp 2", o_fault); else passed++;
    total++; if (o_pc !== 32'h300 || o_retired !== 32'd0) $display("FAIL jalr_frozen: got pc %h ret %0d exp 300 0", o_pc, o_retired); else passed++;
    for (int i = 0; i < 3; i++) begin
      if (o_imem_re || o_reg_we || o_ram_re || o_ram_we) en_cnt++;
      step();
    end
    total++; if (en_cnt != 0 || o_state !== S_HALT) $display("FAIL jalr_stays_halted: got en %0d st %0d exp 0 6", en_cnt, o_state); else passed++;
    setup = 1'b1;
    step();
    total++; if (o_state !== S_SETUP || o_fault !== 2'd0 || o_halted !== 1'b0)
      $display("FAIL halt_exit_setup: got st %0d fault %0d halted %b exp 0 0 0", o_state, o_fault, o_halted); else passed++;
    setup = 1'b0;
  endtask

  task automatic test_illegal(input logic [31:0] addr);
    int en_cnt = 0;
    do_setup(addr);
    step(); step();
    total++; if (o_state !== S_HALT || o_fault !== 2'd1) $display("FAIL illegal_halt_%h: got st %0d fault %0d exp 6 1", addr, o_state, o_fault); else passed++;
    total++; if (o_pc !== addr) $display("FAIL illegal_pc_%h: got %h exp %h", addr, o_pc, addr); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (o_imem_re || o_reg_we || o_ram_re || o_ram_we) en_cnt++;
      step();
    end
    total++; if (en_cnt != 0) $display("FAIL illegal_enables_%h: got %0d exp 0", addr, en_cnt); else passed++;
  endtask

  task automatic test_pc_wrap();
    int we_cnt = 0;
    do_setup(32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) begin if (o_reg_we) we_cnt++; step(); end
    total++; if (o_pc !== 32'h0 || o_retired !== 32'd1) $display("FAIL pc_wrap: got pc %h ret %0d exp 0 1", o_pc, o_retired); else passed++;
    total++; if (we_cnt != 0) $display("FAIL rd_x0_reg_we: got %0d exp 0", we_cnt); else passed++;
  endtask

  task automatic test_abort();
    int bad = 0;
    do_setup(32'h330);
    step(); step(); step();
    total++; if (o_state !== S_MEM || o_ram_re !== 1'b1) $display("FAIL lw_mem_re: got st %0d re %b exp 4 1", o_state, o_ram_re); else passed++;
    setup = 1'b1;
    #1;
    total++; if (o_ram_re !== 1'b0) $display("FAIL setup_gates_re: got %b exp 0", o_ram_re); else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (o_reg_we || o_ram_re || o_ram_we) bad++;
    end
    total++; if (bad != 0 || o_state !== S_SETUP) $display("FAIL setup_abort: got bad %0d st %0d exp 0 0", bad, o_state); else passed++;
    setup = 1'b0;
    // Retire one ADDI, then reset in the middle of the next FETCH.
    do_setup(32'h100);
    step(); step(); step(); step();
    #2; rst_n = 1'b0; #1;
    total++; if (o_state !== S_SETUP || o_pc !== 32'h0 || o_ir !== 32'h0)
      $display("FAIL midfetch_reset: got st %0d pc %h ir %h exp 0 0 0", o_state, o_pc, o_ir); else passed++;
    total++; if (o_retired !== 32'd0 || o_imem_re !== 1'b0 || o_reg_we !== 1'b0)
      $display("FAIL midfetch_reset_outs: got ret %0d re %b we %b exp 0 0 0", o_retired, o_imem_re, o_reg_we); else passed++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
    imem[64]  = 32'h0050_0093; // 0x100 ADDI x1,x0,5
    imem[65]  = 32'h0010_2023; // 0x104 SW x1,0(x0)
    imem[128] = 32'h0000_0063; // 0x200 BEQ
    imem[16]  = 32'h0000_1063; // 0x040 BNE
    imem[192] = 32'h0000_00E7; // 0x300 JALR x1,0(x0)
    imem[196] = 32'h0000_007F; // 0x310 opcode 0x7F
    imem[200] = 32'h0010_0073; // 0x320 EBREAK
    imem[204] = 32'h0000_2103; // 0x330 LW x2,0(x0)
    test_reset();
    test_fetch_alu();
    test_store();
    test_branch();
    test_misaligned_jalr();
    test_illegal(32'h310);
    test_illegal(32'h320);
    test_pc_wrap();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
